// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

  // A word count is usable when it is non-zero and fits in 2^addr_w words.
  function automatic logic len_ok(input logic [LEN_W-1:0] n, input int addr_w);
    logic [LEN_W:0] cap;
    if (n == '0) return 1'b0;
    if (addr_w >= LEN_W) return 1'b1;
    cap = (LEN_W+1)'(1) << addr_w;
    return ({1'b0, n} <= cap);
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Big-endian byte-to-word packer: three bytes are held, the fourth completes a word.
module loader_word_pack
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign o_word     = {r_shift, i_byte};
  assign o_word_vld = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the CPU in reset until done.
// Optional trailing XOR checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            r_state;
  logic [7:0]        r_len_hi;
  logic [LEN_W-1:0]  r_words_left;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic              w_data_en;
  logic [31:0]       w_word;
  logic              w_word_vld;
  logic              w_last;
  logic [LEN_W-1:0]  w_len;

  // A byte offered alongside reload is refused so the new frame starts clean.
  assign rx_ready  = !reload && (r_state != ST_DONE) && (r_state != ST_ERR);
  assign w_accept  = rx_valid && rx_ready;
  assign w_data_en = w_accept && (r_state == ST_DATA);
  assign w_len     = {r_len_hi, rx_data};
  assign w_last    = w_word_vld && (r_words_left == LEN_W'(1));

  loader_word_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (reload),
    .i_en       (w_data_en),
    .i_byte     (rx_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_len_hi     <= '0;
      r_words_left <= '0;
      r_waddr      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (reload) begin
        r_state      <= ST_SYNC;
        r_words_left <= '0;
        r_waddr      <= '0;
        r_hold       <= 1'b1;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum       <= '0;
`endif
      end else begin
        if (w_word_vld) begin
          r_we         <= 1'b1;
          r_addr       <= r_waddr;
          r_wdata      <= w_word;
          r_waddr      <= r_waddr + ADDR_W'(1);
          r_words_left <= r_words_left - LEN_W'(1);
        end
        case (r_state)
          ST_SYNC: begin
            if (w_accept && (rx_data == SYNC_BYTE)) r_state <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            if (w_accept) begin
              r_len_hi <= rx_data;
              r_state  <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (w_accept) begin
              if (len_ok(w_len, ADDR_W)) begin
                r_words_left <= w_len;
                r_waddr      <= '0;
                r_state      <= ST_DATA;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_ERR;
              end
            end
          end
          ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_data_en) r_csum <= r_csum ^ rx_data;
            if (w_last) r_state <= ST_CSUM;
`else
            if (w_last) r_state <= ST_DONE;
`endif
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (w_accept) begin
              if (rx_data == r_csum) begin
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_ERR;
              end
            end
          end
`endif
          // Entering DONE straight from DATA delays release by one cycle so the
          // last word is in memory before the CPU leaves reset.
          ST_DONE: begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end
          ST_ERR: begin
            r_err <= 1'b1;
          end
          default: r_state <= ST_SYNC;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a frame-parsing model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_we_cyc, done_rise_cyc, hold_fall_cyc, err_rise_cyc, last_acc_cyc;
  logic prev_we = 1'b0, prev_done = 1'b0, prev_hold = 1'b1, prev_err = 1'b0;

  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  stream[$];
  logic [31:0] frame_words[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_outcome;   // 0 pending, 1 done, 2 error

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rx_valid && rx_ready) last_acc_cyc = cyc + 1;
  end

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
      last_we_cyc = cyc;
      chk("we_single_cycle", prev_we, 1'b0);
      chk("hold_during_write", cpu_hold, 1'b1);
    end
    if (done && !prev_done)     done_rise_cyc = cyc;
    if (!cpu_hold && prev_hold) hold_fall_cyc = cyc;
    if (error && !prev_err)     err_rise_cyc  = cyc;
    prev_we   = imem_we;
    prev_done = done;
    prev_hold = cpu_hold;
    prev_err  = error;
  end

  // Reference: parse the byte stream the way the frame format defines it.
  task automatic model();
    int i, n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_outcome = 0;
    i = 0;
    while (i < stream.size() && stream[i] != 8'hA5) i++;
    if (i + 2 >= stream.size()) return;
    n = int'(stream[i+1]) * 256 + int'(stream[i+2]);
    i += 3;
    if (n == 0 || n > CAP) begin
      exp_outcome = 2;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      if (i + 4 > stream.size()) return;
      exp_addr.push_back(w);
      exp_data.push_back({stream[i], stream[i+1], stream[i+2], stream[i+3]});
      x = x ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
      i += 4;
    end
    if (!CSUM_EN) exp_outcome = 1;
    else if (i < stream.size()) exp_outcome = (stream[i] == x) ? 1 : 2;
  endtask

  task automatic build_frame(input int n, input bit bad_csum);
    logic [7:0] x;
    logic [15:0] n16;
    n16 = n[15:0];
    stream.push_back(8'hA5);
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    if (n == 0 || n > CAP) return;
    x = 8'h00;
    foreach (frame_words[k]) begin
      for (int b = 3; b >= 0; b--) begin
        stream.push_back(frame_words[k][b*8 +: 8]);
        x = x ^ frame_words[k][b*8 +: 8];
      end
    end
    if (CSUM_EN) stream.push_back(bad_csum ? (x ^ 8'h01) : x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap + 1) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    k = 0;
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!rx_ready) begin
      chk("send_timeout", 1'b0, 1'b1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    #1;
    chk("reload_blocks_ready", rx_ready, 1'b0);
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("reload_hold", cpu_hold, 1'b1);
    chk("reload_done", done, 1'b0);
    chk("reload_error", error, 1'b0);
    chk("reload_ready", rx_ready, 1'b1);
  endtask

  task automatic run_frame(input string tag, input int gap, input bit rand_gap);
    last_we_cyc = -1; done_rise_cyc = -1; hold_fall_cyc = -1; err_rise_cyc = -1; last_acc_cyc = -1;
    got_addr.delete();
    got_data.delete();
    model();
    foreach (stream[j]) send_byte(stream[j], rand_gap ? int'($urandom_range(0, 2)) : gap);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    foreach (exp_addr[k]) begin
      if (k < got_addr.size()) begin
        chk({tag, "_addr"}, got_addr[k], exp_addr[k]);
        chk({tag, "_data"}, got_data[k], exp_data[k]);
      end
    end
    chk({tag, "_done"}, done, exp_outcome == 1);
    chk({tag, "_error"}, error, exp_outcome == 2);
    chk({tag, "_hold"}, cpu_hold, exp_outcome != 1);
    chk({tag, "_ready"}, rx_ready, exp_outcome == 0);
    if (exp_outcome == 1) begin
      if (CSUM_EN) chk({tag, "_done_lat"}, done_rise_cyc, last_acc_cyc);
      else begin
        chk({tag, "_we_lat"}, last_we_cyc, last_acc_cyc);
        chk({tag, "_done_lat"}, done_rise_cyc, last_we_cyc + 1);
      end
      chk({tag, "_hold_lat"}, hold_fall_cyc, done_rise_cyc);
    end
    if (exp_outcome == 2) chk({tag, "_err_lat"}, err_rise_cyc, last_acc_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] g;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    #12;
    chk("rst_ready", rx_ready, 1'b1);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, '0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic two-word frame.
    stream.delete();
    frame_words = {32'h12345678, 32'h9ABCDEF0};
    build_frame(2, 1'b0);
    run_frame("basic", 0, 1'b0);
    chk("basic_w0_literal", got_data.size() > 0 ? got_data[0] : 32'hx, 32'h12345678);
    chk("basic_w1_literal", got_data.size() > 1 ? got_data[1] : 32'hx, 32'h9ABCDEF0);

    // Garbage before sync is discarded.
    do_reload();
    stream = {8'h00, 8'hFF, 8'h3C};
    build_frame(2, 1'b0);
    run_frame("garbage", 0, 1'b0);

    // Zero length and oversize length.
    do_reload();
    stream.delete();
    frame_words.delete();
    build_frame(0, 1'b0);
    run_frame("len_zero", 0, 1'b0);
    do_reload();
    stream.delete();
    build_frame(CAP + 1, 1'b0);
    run_frame("len_over", 0, 1'b0);

    // Throttled source: one byte every third cycle.
    do_reload();
    stream.delete();
    frame_words = {32'h12345678, 32'h9ABCDEF0};
    build_frame(2, 1'b0);
    run_frame("throttle", 2, 1'b0);

    // Capacity boundary: exactly 2^ADDR_W words.
    do_reload();
    stream.delete();
    frame_words.delete();
    for (int k = 0; k < CAP; k++) frame_words.push_back($urandom);
    build_frame(CAP, 1'b0);
    run_frame("full", 0, 1'b0);

    if (CSUM_EN) begin
      do_reload();
      stream.delete();
      frame_words = {32'h11223344};
      build_frame(1, 1'b0);
      run_frame("csum_good", 0, 1'b0);
      chk("csum_byte_literal", stream[stream.size()-1], 8'h44);
      do_reload();
      stream.delete();
      build_frame(1, 1'b1);
      run_frame("csum_bad", 0, 1'b0);
      do_reload();
      stream.delete();
      build_frame(1, 1'b0);
      run_frame("csum_recover", 0, 1'b0);
    end

    // Reload mid-frame discards the partial word.
    do_reload();
    stream = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
    foreach (stream[j]) send_byte(stream[j], 0);
    do_reload();
    stream.delete();
    frame_words = {32'hCAFEF00D};
    build_frame(1, 1'b0);
    run_frame("reload_mid", 0, 1'b0);

    // Randomized frames with garbage, gaps, bad lengths and bad checksums.
    for (int it = 0; it < 12; it++) begin
      do_reload();
      stream.delete();
      frame_words.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        stream.push_back(g);
      end
      case ($urandom_range(0, 5))
        0:       n = 0;
        1:       n = CAP + int'($urandom_range(1, 500));
        default: n = int'($urandom_range(1, 6));
      endcase
      if (n > 0 && n <= CAP) repeat (n) frame_words.push_back($urandom);
      build_frame(n, $urandom_range(0, 2) == 0);
      run_frame("random", 0, 1'b1);
    end

    // Asynchronous reset after five data bytes, then a fresh frame.
    do_reload();
    got_addr.delete();
    got_data.delete();
    stream = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    foreach (stream[j]) send_byte(stream[j], 0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", imem_we, 1'b0);
    chk("arst_addr", imem_addr, '0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_hold", cpu_hold, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_ready", rx_ready, 1'b1);
    chk("arst_prior_writes", got_addr.size(), 1);
    @(negedge clk);
    reset = 1'b0;
    stream.delete();
    frame_words = {32'hDEADBEEF};
    build_frame(1, 1'b0);
    run_frame("after_reset", 0, 1'b0);
    chk("after_reset_literal", got_data.size() > 0 ? got_data[0] : 32'hx, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the MIPS CPU's instruction memory and holds the CPU in reset until loading completes. It receives a framed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them to consecutive word addresses from 0. It sits between a host byte source (UART receiver or bench driver) and the instruction-memory write port. Its `cpu_hold` output is ORed into the `Cpu` reset.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: byte source has data.
- `rx_data` in 8: byte from the source.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a cycle where `rx_valid && rx_ready`.
- `reload` in 1: restart loading. Single-cycle pulse.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: instruction word.
- `cpu_hold` out 1: CPU held in reset while high.
- `done` out 1: load completed successfully.
- `error` out 1: frame rejected.

## Operation
- Frame format: sync byte 0xA5, then word count N as 16 bits (high byte, then low byte), then 4·N data bytes (MSB first per word), then an optional checksum byte (see Configuration).
- States and transitions:
  - SYNC: non-0xA5 bytes are accepted and discarded. 0xA5 -> LEN_HI.
  - LEN_HI -> LEN_LO. Captures the count high byte.
  - LEN_LO: if N==0 or N>2^ADDR_W -> ERR, otherwise -> DATA.
  - DATA: counts bytes. Every 4th byte produces a word write. After the last byte -> CSUM when the checksum is enabled, otherwise -> DONE.
  - CSUM: match -> DONE, mismatch -> ERR.
  - DONE and ERR are terminal until `reload` or `reset`.
- `rx_ready` is 1 in SYNC, LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERR. It is a combinational decode of the registered state.
- Word addresses run 0..N-1 with no wrap. N is range-checked before any write, so overflow cannot occur.
- `reload` is honoured in any state and returns the block to SYNC:
  - A partial word is discarded and the byte counter and address clear.
  - `cpu_hold` goes to 1; `done` and `error` go to 0.
  - A byte presented in the same cycle as `reload` is not accepted (`rx_ready` is forced to 0 that cycle).
- Data already written to memory before an ERR is not rolled back. `cpu_hold` stays 1 in ERR.

## Timing
- Reset values: state SYNC, `rx_ready`=1 (decoded), `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0.
- Write latency: the 4th byte of a word is accepted at edge E. `imem_we`=1 with the valid address and data for exactly the one cycle after E. `imem_addr` and `imem_wdata` are registered.
- Completion without checksum: the final word write occurs in cycle T. `done`=1 and `cpu_hold`=0 from cycle T+1. Memory is therefore written strictly before the CPU leaves reset.
- Completion with checksum: the checksum byte is accepted at edge E and `done` or `error` rises in the cycle after E. On success `cpu_hold` falls in that same cycle.
- `error` on a bad length rises the cycle after the length-low byte is accepted.
- Asynchronous `reset` mid-frame forces all reset values immediately. The next frame loads from address 0.
- One byte per cycle is sustained. Gaps in `rx_valid` only stall the loader.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - The expected checksum is the XOR of all 4·N data bytes. Length bytes and the sync byte are excluded.
  - A mismatch -> ERR.
- Not defined: no CSUM state; DATA -> DONE directly, and no trailing byte is expected.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum (SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - `SYNC_BYTE`=8'hA5;
  - `LEN_W`=16.
- Sub-module `loader_word_pack` is the byte-to-word shift register with a 2-bit byte counter and a word-complete pulse. The top level holds the FSM, the address counter, the checksum accumulator and the outputs.

## Test plan
- Reset, then send A5 00 02 12 34 56 78 9A BC DE F0 -> writes: addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0; `done`=1, `cpu_hold`=0 one cycle after the second write.
- Send 00 FF 3C, then the frame above -> garbage ignored; identical writes and `done`.
- Send A5 00 00, and separately A5 01 01 with ADDR_W=8 -> `error`=1, no `imem_we`, `rx_ready`=0, `cpu_hold`=1.
- Same frame as the first test with `rx_valid` high only every third cycle -> identical writes and addresses; `imem_we` never asserted for more than one cycle.
- With `IMEM_LOADER_CHECKSUM_EN`, frame A5 00 01 11 22 33 44 plus checksum 0x44 -> `done`. With checksum 0x45 -> `error`=1, `cpu_hold`=1. Then pulse `reload` and send a good frame -> `done`.
- Assert `reset` after 5 data bytes -> outputs at reset values; a new frame A5 00 01 DE AD BE EF -> addr 0 = 0xDEADBEEF.
